// File: rtl/seq_div_16b.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with a
// start/busy/done handshake. Divide-by-zero short-circuits to a flagged result.
module seq_div_16b #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // Trial subtraction datapath: shifted + ~{0,divisor} + 1 as an explicit ripple chain.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] carry;
  logic             no_borrow;
  logic [WIDTH:0]   prem_next;
  logic [WIDTH-1:0] quo_next;

  // The partial remainder stays below the divisor, so its MSB is never shifted out.
  logic unused_prem_msb;
  assign unused_prem_msb = prem_q[WIDTH];

  always_comb begin
    shifted  = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    sub_b    = ~{1'b0, dvs_q};
    trial    = '0;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i <= int'(WIDTH); i++) begin
      trial[i]   = shifted[i] ^ sub_b[i] ^ carry[i];
      carry[i+1] = (shifted[i] & sub_b[i]) | (carry[i] & (shifted[i] ^ sub_b[i]));
    end
    no_borrow = carry[WIDTH+1];
    prem_next = no_borrow ? trial : shifted;
    quo_next  = {dvd_q[WIDTH-2:0], no_borrow};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      // DONE accepts a new start exactly like IDLE, enabling back-to-back operation.
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            prem_d  = '0;
            cnt_d   = CntW'(WIDTH - 1);
            state_d = StCalc;
          end else begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StCalc: begin
        // Dividend register shifts out its MSB and collects quotient bits at the LSB.
        prem_d = prem_next;
        dvd_d  = quo_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quo_d   = quo_next;
          rem_d   = prem_next[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == StCalc);
  assign done        = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_16b.sv
// Directed-vector and corner-sequence bench for seq_div_16b (WIDTH=16).
module tb_seq_div_16b;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_div_16b #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle or in DONE; returns at the negedge after acceptance.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
  endtask

  // edges = index k of the edge E_k after which done is seen (accepting edge is E0).
  task automatic wait_done(input string nm, output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    while (!done && edges < 64) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
    if (!done) chk({nm, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int edges, bcnt;
    start_op(v.a, v.b);
    wait_done(nm, edges, bcnt);
    chk({nm, "_lat"}, 32'(edges), (v.b != 0) ? 32'd16 : 32'd0);
    chk({nm, "_busycyc"}, 32'(bcnt), (v.b != 0) ? 32'd16 : 32'd0);
    chk({nm, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({nm, "_q"}, 32'(quotient), 32'(v.q));
    chk({nm, "_r"}, 32'(remainder), 32'(v.r));
    chk({nm, "_dbz"}, 32'(div_by_zero), 32'(v.dbz));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_q"}, 32'(quotient), 32'd0);
    chk({nm, "_r"}, 32'(remainder), 32'd0);
    chk({nm, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    int edges, bcnt, ndone, first_done;
    logic [15:0] a, b;
    logic [31:0] recon;
    vec_t v;

    vecs[0] = '{a: 16'd100,    b: 16'd7,      q: 16'd14,     r: 16'd2,      dbz: 1'b0};
    vecs[1] = '{a: 16'hFFFF,   b: 16'h0001,   q: 16'hFFFF,   r: 16'h0000,   dbz: 1'b0};
    vecs[2] = '{a: 16'h0005,   b: 16'h0009,   q: 16'h0000,   r: 16'h0005,   dbz: 1'b0};
    vecs[3] = '{a: 16'hFFFF,   b: 16'hFFFF,   q: 16'h0001,   r: 16'h0000,   dbz: 1'b0};
    vecs[4] = '{a: 16'h04D2,   b: 16'h0000,   q: 16'hFFFF,   r: 16'h04D2,   dbz: 1'b1};
    vecs[5] = '{a: 16'h0000,   b: 16'h0005,   q: 16'h0000,   r: 16'h0000,   dbz: 1'b0};
    vecs[6] = '{a: 16'h8000,   b: 16'h0003,   q: 16'd10922,  r: 16'd2,      dbz: 1'b0};
    vecs[7] = '{a: 16'h1234,   b: 16'h0100,   q: 16'h0012,   r: 16'h0034,   dbz: 1'b0};
    vecs[8] = '{a: 16'hABCD,   b: 16'hABCE,   q: 16'h0000,   r: 16'hABCD,   dbz: 1'b0};
    vecs[9] = '{a: 16'd100,    b: 16'd7,      q: 16'd14,     r: 16'd2,      dbz: 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Inputs changed and start re-pulsed mid-calculation must be ignored; result held meanwhile.
    start_op(16'd1000, 16'd10);
    ndone      = 0;
    first_done = -1;
    for (int k = 0; k < 40; k++) begin
      if (k == 4) begin
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
      end else if (k == 5) begin
        start    = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 16'h0000;
      end
      if (k == 8) chk("midcalc_hold_q", 32'(quotient), 32'd14);
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
      @(negedge clk);
    end
    chk("ignore_ndone", 32'(ndone), 32'd1);
    chk("ignore_lat", 32'(first_done), 32'd16);
    chk("ignore_q", 32'(quotient), 32'd100);
    chk("ignore_r", 32'(remainder), 32'd0);

    // Asynchronous reset in the 8th cycle of CALC aborts with no done pulse.
    start_op(16'd200, 16'd3);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midreset_nodone", 32'(ndone), 32'd0);
    v = '{a: 16'd200, b: 16'd3, q: 16'd66, r: 16'd2, dbz: 1'b0};
    run_vec("after_reset", v);

    // Back-to-back: start held in the DONE cycle.
    start_op(16'd50, 16'd7);
    wait_done("b2b_first", edges, bcnt);
    chk("b2b_first_lat", 32'(edges), 32'd16);
    chk("b2b_first_q", 32'(quotient), 32'd7);
    chk("b2b_first_r", 32'(remainder), 32'd1);
    start_op(16'd81, 16'd9);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b_second", edges, bcnt);
    chk("b2b_second_lat", 32'(edges), 32'd16);
    chk("b2b_second_q", 32'(quotient), 32'd9);
    chk("b2b_second_r", 32'(remainder), 32'd0);
    @(negedge clk);

    // Random sweep against the arithmetic reference and the division invariant.
    for (int n = 0; n < 1500; n++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(1, 65535));
      start_op(a, b);
      wait_done("rand", edges, bcnt);
      chk($sformatf("rand%0d_q(%0h/%0h)", n, a, b), 32'(quotient), 32'(a / b));
      chk($sformatf("rand%0d_r(%0h/%0h)", n, a, b), 32'(remainder), 32'(a % b));
      recon = 32'(quotient) * 32'(b) + 32'(remainder);
      chk($sformatf("rand%0d_inv", n), recon, 32'(a));
      chk($sformatf("rand%0d_rlt", n), 32'(remainder < b), 32'd1);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
